// File: rtl/signed_divider_if.sv
// Operand/result handshake bundle for the 16/8 signed divider.
// The master side supplies operands and takes results; the slave side is the divider.
interface signed_divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;
  logic        ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/signed_divider.sv
// Sequential 16-bit / 8-bit signed divider: restoring division on magnitudes,
// sign correction afterwards, results held until the next load.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | 16 shift-subtract steps on magnitudes
// FIX   | apply signs, register quotient/remainder/flags
// DONE  | result presented until out_ready
module signed_divider (
  input  logic             clk,
  input  logic             rst_n,
  signed_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [16:0] prem_q, prem_d;
  logic [7:0]  dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [15:0] quotient_q, quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [15:0] dvd_mag;
  logic [7:0]  dvs_mag;
  logic [16:0] prem_shift;
  logic [16:0] prem_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      prem_q      <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prem_q      <= prem_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    // Unsigned magnitudes: -32768 -> 16'h8000 and -128 -> 8'h80 stay exact.
    dvd_mag    = bus.dividend[15] ? (16'd0 - bus.dividend) : bus.dividend;
    dvs_mag    = bus.divisor[7]   ? (8'd0 - bus.divisor)   : bus.divisor;
    prem_shift = (prem_q << 1) | {16'd0, acc_q[15]};
    prem_diff  = prem_shift - {9'd0, dvs_q};

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prem_d      = prem_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cnt_d = '0;
          if (bus.divisor == 8'd0) begin
            quotient_d  = '0;
            remainder_d = '0;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            state_d     = DONE;
          end else begin
            acc_d     = dvd_mag;
            dvs_d     = dvs_mag;
            prem_d    = '0;
            neg_quo_d = bus.dividend[15] ^ bus.divisor[7];
            neg_rem_d = bus.dividend[15];
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        // Quotient bits shift into acc as dividend bits shift out of it.
        if (!prem_diff[16]) begin
          prem_d = prem_diff;
          acc_d  = {acc_q[14:0], 1'b1};
        end else begin
          prem_d = prem_shift;
          acc_d  = {acc_q[14:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = FIX;
      end
      FIX: begin
        quotient_d  = neg_quo_q ? (16'd0 - acc_q) : acc_q;
        remainder_d = neg_rem_q ? (8'd0 - prem_q[7:0]) : prem_q[7:0];
        dbz_d       = 1'b0;
        // Only -32768 / -1 yields a positive magnitude of 32768.
        ovf_d       = !neg_quo_q && acc_q[15];
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: directed hand-computed vectors, backpressure,
// reset abort, then a random sweep against a behavioural reference.
module tb_signed_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  signed_divider_if dif ();

  signed_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] q, input logic [7:0] r,
                              input logic dbz, input logic ovf);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf;
    return e;
  endfunction

  // Reference: language division truncates toward zero, % follows the dividend's sign.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    int   ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    e  = '0;
    if (bi == 0) begin
      e.dbz = 1'b1;
    end else begin
      qi    = ai / bi;
      ri    = ai % bi;
      e.q   = qi[15:0];
      e.r   = ri[7:0];
      e.ovf = (qi == 32768);
    end
    return e;
  endfunction

  // Monitor: compare on every handshake; an unexpected result counts as a miscompare.
  always @(negedge clk) begin
    if (rst_n && dif.out_valid && dif.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got q=%0h r=%0h with empty scoreboard", dif.quotient, dif.remainder);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("quotient",  32'(dif.quotient),  32'(e.q));
        chk("remainder", 32'(dif.remainder), 32'(e.r));
        chk("dbz",       32'(dif.dbz),       32'(e.dbz));
        chk("ovf",       32'(dif.ovf),       32'(e.ovf));
      end
    end
  end

  // Present operands and return right after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int k;
    @(posedge clk); #1;
    dif.dividend = a;
    dif.divisor  = b;
    dif.in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (dif.in_ready) break;
    end
    if (k == 50) chk("accept_timeout", 32'(dif.in_ready), 32'd1);
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
  endtask

  // k = number of falling-edge samples after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int k);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (dif.out_valid) break;
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 50; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (k == 50) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input exp_t e);
    int k;
    sb_q.push_back(e);
    issue(a, b);
    wait_valid(k);
    if (b == 8'd0) chk("dbz_latency_cycles", 32'(k), 32'd1);
    else           chk("latency_edges", 32'(k - 1), 32'd17);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int k;
    logic [15:0] ra;
    logic [7:0]  rb;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    dif.dividend  = '0;
    dif.divisor   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_quotient",  32'(dif.quotient),  32'd0);
    chk("rst_remainder", 32'(dif.remainder), 32'd0);
    chk("rst_dbz",       32'(dif.dbz),       32'd0);
    chk("rst_ovf",       32'(dif.ovf),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(dif.in_ready), 32'd1);

    do_op(16'd1000, 8'd7, mk(16'd142, 8'd6, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    chk("retain_quotient",  32'(dif.quotient),  32'd142);
    chk("retain_remainder", 32'(dif.remainder), 32'd6);
    chk("idle_out_valid",   32'(dif.out_valid), 32'd0);
    chk("idle_in_ready",    32'(dif.in_ready),  32'd1);

    do_op(-16'sd1000, 8'd7,    mk(-16'sd142, -8'sd6, 1'b0, 1'b0));
    do_op(16'd1000,   -8'sd7,  mk(-16'sd142, 8'd6,   1'b0, 1'b0));
    do_op(-16'sd1000, -8'sd7,  mk(16'd142,   -8'sd6, 1'b0, 1'b0));
    do_op(16'h8000,   8'hFF,   mk(16'h8000,  8'd0,   1'b0, 1'b1));
    do_op(16'd5,      8'd0,    mk(16'd0,     8'd0,   1'b1, 1'b0));
    do_op(16'h8000,   8'h80,   mk(16'd256,   8'd0,   1'b0, 1'b0));
    do_op(16'd32767,  8'd127,  mk(16'd258,   8'd1,   1'b0, 1'b0));
    do_op(16'h8000,   8'd1,    mk(16'h8000,  8'd0,   1'b0, 1'b0));
    do_op(16'd0,      8'd5,    mk(16'd0,     8'd0,   1'b0, 1'b0));
    do_op(16'd7,      8'd8,    mk(16'd0,     8'd7,   1'b0, 1'b0));
    do_op(-16'sd7,    8'd8,    mk(16'd0,     -8'sd7, 1'b0, 1'b0));
    do_op(16'd32767,  8'h80,   mk(-16'sd255, 8'd127, 1'b0, 1'b0));

    // Backpressure: result must hold and a second request must be ignored.
    dif.out_ready = 1'b0;
    sb_q.push_back(mk(-16'sd246, 8'd4, 1'b0, 1'b0));
    issue(16'd1234, -8'sd5);
    wait_valid(k);
    chk("bp_latency_edges", 32'(k - 1), 32'd17);
    @(posedge clk); #1;
    dif.dividend = 16'd99;
    dif.divisor  = 8'd1;
    dif.in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(dif.out_valid), 32'd1);
      chk("bp_quotient",  32'(dif.quotient),  32'hFF0A);
      chk("bp_remainder", 32'(dif.remainder), 32'd4);
      chk("bp_flags",     32'({dif.dbz, dif.ovf}), 32'd0);
      chk("bp_in_ready",  32'(dif.in_ready),  32'd0);
    end
    @(posedge clk); #1;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("bp_no_second_result", 32'(dif.out_valid), 32'd0);

    // Reset in the middle of CALC: nothing may be produced for the aborted division.
    issue(16'd1000, 8'd7);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(dif.out_valid), 32'd0);
    chk("abort_quotient",  32'(dif.quotient),  32'd0);
    chk("abort_remainder", 32'(dif.remainder), 32'd0);
    chk("abort_flags",     32'({dif.dbz, dif.ovf}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(dif.in_ready), 32'd1);
    do_op(16'd100, -8'sd3, mk(-16'sd33, 8'd1, 1'b0, 1'b0));

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if (i % 15 == 0) rb = 8'd0;
      if (i % 20 == 7) ra = 16'h8000;
      do_op(ra, rb, model(ra, rb));
    end

    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter: none; widths fixed at 16-bit dividend, 8-bit divisor.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operands present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port dividend, input, 16, signed two's-complement numerator.
REQ-007 SHALL have port divisor, input, 8, signed two's-complement denominator.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port quotient, output, 16, signed quotient.
REQ-011 SHALL have port remainder, output, 8, signed remainder.
REQ-012 SHALL have port dbz, output, 1, divide-by-zero flag, valid with out_valid.
REQ-013 SHALL have port ovf, output, 1, quotient-overflow flag, valid with out_valid.

Function
REQ-014 SHALL compute quotient truncated toward zero; remainder takes the dividend's sign; dividend == quotient*divisor + remainder; |remainder| < |divisor|.
REQ-015 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL, in IDLE on in_valid&&in_ready, capture operand magnitudes and result signs, clear the 4-bit iteration counter, go to CALC; operands are not sampled at any other time.
REQ-018 SHALL, on acceptance with divisor == 0, go directly to DONE with quotient=0, remainder=0, dbz=1, ovf=0.
REQ-019 SHALL, in CALC, perform one unsigned restoring shift-subtract step per cycle (17-bit partial remainder vs 8-bit |divisor|), MSB of |dividend| first, exactly 16 steps, then go to FIX.
REQ-020 SHALL, in FIX, negate quotient if operand signs differ and negate remainder if dividend negative, register outputs, go to DONE.
REQ-021 SHALL, for dividend=-32768 and divisor=-1, set ovf=1 and quotient=16'h8000, remainder=0.
REQ-022 SHALL assert out_valid exactly 17 cycles after the accepting edge for non-zero divisor, 1 cycle for zero divisor.
REQ-023 SHALL hold quotient, remainder, dbz, ovf, out_valid stable while out_valid && !out_ready.
REQ-024 SHALL, on out_valid&&out_ready, return to IDLE; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-025 SHALL retain quotient/remainder/flags after handoff until the next FIX or DBZ load.
REQ-026 SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-027 SHALL handle |divisor|=128 (divisor=-128) and dividend=-32768 correctly using unsigned magnitudes (e.g. -32768/-128 = 256 r 0).

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, counter 0, quotient=0, remainder=0, dbz=0, ovf=0, out_valid=0, in_ready=1 after release.
REQ-029 SHALL abort any in-progress division on reset assertion in any state; no result is produced for the aborted operation.

Verification
REQ-030 SHALL check 1000 / 7 -> quotient=142, remainder=6, dbz=0, ovf=0, out_valid 17 cycles after accept.
REQ-031 SHALL check -1000 / 7 -> 142 negated (-142), remainder=-6; and 1000 / -7 -> -142, remainder=6.
REQ-032 SHALL check -32768 / -1 -> ovf=1, quotient=16'h8000, remainder=0; and 5 / 0 -> dbz=1, quotient=0, out_valid 1 cycle after accept.
REQ-033 SHALL check backpressure: out_ready held 0 for 10 cycles in DONE -> outputs and out_valid unchanged, in_ready=0, second in_valid ignored.
REQ-034 SHALL check rst_n pulse at CALC step 8 -> all outputs 0, in_ready=1 after release, next operation 100 / -3 -> -33 remainder 1.
REQ-035 SHALL run a random sweep of all-legal operand pairs against a reference model per REQ-014/018/021.
